// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman array sequencer: default widths,
// FSM state encoding and the 2-bit DNA alphabet.
package sw_pkg;

   localparam int CHAR_W_DEF  = 2;
   localparam int SCORE_W_DEF = 16;
   localparam int LEN_W_DEF   = 16;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CLEAR  = 3'd1;
   localparam logic [2:0] ST_LOAD   = 3'd2;
   localparam logic [2:0] ST_STREAM = 3'd3;
   localparam logic [2:0] ST_DRAIN  = 3'd4;
   localparam logic [2:0] ST_RESULT = 3'd5;

   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_C = 2'd1;
   localparam logic [1:0] CH_G = 2'd2;
   localparam logic [1:0] CH_T = 2'd3;

endpackage

// File: rtl/sw_array_ctrl_if.sv
// Host job/stream channels and cell-array control bundle for sw_array_ctrl.
// Every channel is valid/ready: a transfer happens on a rising edge where both are high.
interface sw_array_ctrl_if #(
   parameter int NUM_CELLS = 8,
   parameter int CHAR_W    = 2,
   parameter int SCORE_W   = 16,
   parameter int LEN_W     = 16
);
   logic                 start_valid;
   logic                 start_ready;
   logic [LEN_W-1:0]     start_ref_len;
   logic                 q_valid;
   logic                 q_ready;
   logic [CHAR_W-1:0]    q_char;
   logic                 ref_valid;
   logic                 ref_ready;
   logic [CHAR_W-1:0]    ref_char;
   logic                 arr_clear;
   logic [NUM_CELLS-1:0] cell_q_we;
   logic [CHAR_W-1:0]    cell_q_char;
   logic                 arr_in_valid;
   logic [CHAR_W-1:0]    arr_in_char;
   logic                 arr_score_valid;
   logic [SCORE_W-1:0]   arr_score;
   logic                 res_valid;
   logic                 res_ready;
   logic [SCORE_W-1:0]   res_score;
   logic [LEN_W-1:0]     res_pos;

   modport slave (
      input  start_valid, start_ref_len, q_valid, q_char, ref_valid, ref_char,
             arr_score_valid, arr_score, res_ready,
      output start_ready, q_ready, ref_ready, arr_clear, cell_q_we, cell_q_char,
             arr_in_valid, arr_in_char, res_valid, res_score, res_pos
   );

   modport master (
      output start_valid, start_ref_len, q_valid, q_char, ref_valid, ref_char,
             arr_score_valid, arr_score, res_ready,
      input  start_ready, q_ready, ref_ready, arr_clear, cell_q_we, cell_q_char,
             arr_in_valid, arr_in_char, res_valid, res_score, res_pos
   );

endinterface

// File: rtl/sw_max_tracker.sv
// Running maximum of the array's score samples and the sample index where it
// first occurred; ties keep the earlier position.
module sw_max_tracker #(
   parameter int SCORE_W = 16,
   parameter int LEN_W   = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   input  logic               sample_valid,
   input  logic [SCORE_W-1:0] sample_score,
   output logic [SCORE_W-1:0] best_score,
   output logic [LEN_W-1:0]   best_pos
);

   logic [LEN_W-1:0] sample_cnt;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         best_score <= '0;
         best_pos   <= '0;
         sample_cnt <= '0;
      end else if (enable && sample_valid) begin
         if (sample_score > best_score) begin
            best_score <= sample_score;
            best_pos   <= sample_cnt;
         end
         // Saturate so a very long reference cannot wrap the position.
         if (sample_cnt != {LEN_W{1'b1}}) sample_cnt <= sample_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sw_array_ctrl.sv
// Job sequencer for the linear Smith-Waterman cell array:
// clear -> load query -> stream reference -> drain -> report best score.
module sw_array_ctrl
   import sw_pkg::*;
#(
   parameter int NUM_CELLS = 8,
   parameter int CHAR_W    = CHAR_W_DEF,
   parameter int SCORE_W   = SCORE_W_DEF,
   parameter int LEN_W     = LEN_W_DEF
) (
   input  logic           clock,
   input  logic           reset,
   sw_array_ctrl_if.slave bus,
   output logic           busy,
   output state_t         state
);

   localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CELLS - 1);
   localparam logic [NUM_CELLS-1:0] ONE_HOT0 = NUM_CELLS'(1);

   state_t             state_r;
   logic [LEN_W-1:0]   ref_len_r;
   logic [LEN_W-1:0]   ref_cnt;
   logic [IDX_W-1:0]   q_idx;
   logic [IDX_W-1:0]   drain_cnt;
   logic               start_fire;
   logic               q_fire;
   logic               ref_fire;
   logic               res_fire;
   logic               track_en;
   logic [SCORE_W-1:0] best_score;
   logic [LEN_W-1:0]   best_pos;

   // Readies and strobes are masked by reset so nothing handshakes mid-reset.
   assign bus.start_ready  = !reset && (state_r == ST_IDLE);
   assign bus.q_ready      = !reset && (state_r == ST_LOAD);
   assign bus.ref_ready    = !reset && (state_r == ST_STREAM);
   assign bus.res_valid    = !reset && (state_r == ST_RESULT);
   assign bus.arr_clear    = !reset && (state_r == ST_CLEAR);

   assign start_fire = bus.start_valid && bus.start_ready;
   assign q_fire     = bus.q_valid && bus.q_ready;
   assign ref_fire   = bus.ref_valid && bus.ref_ready;
   assign res_fire   = bus.res_valid && bus.res_ready;
   assign track_en   = (state_r == ST_STREAM) || (state_r == ST_DRAIN);

   assign bus.cell_q_we    = q_fire ? (ONE_HOT0 << q_idx) : '0;
   assign bus.cell_q_char  = q_fire ? bus.q_char : '0;
   assign bus.arr_in_valid = ref_fire;
   assign bus.arr_in_char  = ref_fire ? bus.ref_char : '0;
   assign bus.res_score    = bus.res_valid ? best_score : '0;
   assign bus.res_pos      = bus.res_valid ? best_pos : '0;

   assign busy  = (state_r != ST_IDLE);
   assign state = state_r;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         ref_len_r <= '0;
         ref_cnt   <= '0;
         q_idx     <= '0;
         drain_cnt <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_fire) begin
                  ref_len_r <= bus.start_ref_len;
                  state_r   <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               ref_cnt   <= '0;
               q_idx     <= '0;
               drain_cnt <= '0;
               state_r   <= ST_LOAD;
            end
            ST_LOAD: begin
               if (q_fire) begin
                  q_idx <= q_idx + 1'b1;
                  if (q_idx == LAST_IDX)
                     state_r <= (ref_len_r == '0) ? ST_DRAIN : ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (ref_fire) begin
                  ref_cnt <= ref_cnt + 1'b1;
                  if (ref_cnt == ref_len_r - 1'b1) state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // One cycle per cell lets the last reference char reach the end.
               drain_cnt <= drain_cnt + 1'b1;
               if (drain_cnt == LAST_IDX) state_r <= ST_RESULT;
            end
            ST_RESULT: begin
               if (res_fire) state_r <= ST_IDLE;
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   sw_max_tracker #(
      .SCORE_W (SCORE_W),
      .LEN_W   (LEN_W)
   ) u_tracker (
      .clock        (clock),
      .reset        (reset),
      .clear        (state_r == ST_CLEAR),
      .enable       (track_en),
      .sample_valid (bus.arr_score_valid),
      .sample_score (bus.arr_score),
      .best_score   (best_score),
      .best_pos     (best_pos)
   );

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Self-checking bench for sw_array_ctrl: scenario tasks plus a best-score
// reference model over the score samples fed during STREAM/DRAIN.
module tb_sw_array_ctrl;
   import sw_pkg::*;

   localparam int NC = 8;
   localparam int CW = 2;
   localparam int SW = 16;
   localparam int LW = 16;

   logic   clock = 1'b0;
   logic   reset;
   logic   busy;
   state_t state;

   sw_array_ctrl_if #(.NUM_CELLS(NC), .CHAR_W(CW), .SCORE_W(SW), .LEN_W(LW)) bus ();

   sw_array_ctrl #(.NUM_CELLS(NC), .CHAR_W(CW), .SCORE_W(SW), .LEN_W(LW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave),
      .busy  (busy),
      .state (state)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   logic [CW-1:0] exp_q[$];
   logic [SW-1:0] samp_q[$];
   int            plan_q[$];
   bit            rand_scores;
   logic [CW-1:0] qch[NC];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // tracked=1: a sample the DUT must score; tracked=0: max-valued noise it must ignore.
   task automatic drive_score(input bit tracked);
      int v;
      if (!tracked) begin
         bus.arr_score_valid = 1'b1;
         bus.arr_score = '1;
         return;
      end
      if (plan_q.size() > 0) v = plan_q.pop_front();
      else if (rand_scores) v = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 200));
      else v = -1;
      if (v < 0) begin
         bus.arr_score_valid = 1'b0;
         bus.arr_score = SW'($urandom);
      end else begin
         bus.arr_score_valid = 1'b1;
         bus.arr_score = SW'(v);
         samp_q.push_back(SW'(v));
      end
   endtask

   function automatic void model(output logic [SW-1:0] best, output logic [LW-1:0] pos);
      best = '0;
      pos = '0;
      foreach (samp_q[j]) begin
         if (samp_q[j] > best) begin
            best = samp_q[j];
            pos = LW'(j);
         end
      end
   endfunction

   task automatic do_start(input int len);
      samp_q.delete();
      exp_q.delete();
      bus.start_valid = 1'b1;
      bus.start_ref_len = LW'(len);
      bus.res_ready = 1'b1;
      drive_score(0);
      @(negedge clock);
      checks++;
      if (bus.start_ready !== 1'b1) begin
         errors++; $display("FAIL start_ready_idle: got %b expected 1", bus.start_ready);
      end
      step();
      bus.start_valid = 1'b1;
      bus.start_ref_len = LW'($urandom);
      @(negedge clock);
      checks++;
      if (bus.arr_clear !== 1'b1) begin
         errors++; $display("FAIL arr_clear: got %b expected 1", bus.arr_clear);
      end
      checks++;
      if (bus.start_ready !== 1'b0) begin
         errors++; $display("FAIL start_ready_busy: got %b expected 0", bus.start_ready);
      end
      step();
   endtask

   task automatic do_load(input bit q_gap);
      logic [NC-1:0] we_exp;
      for (int i = 0; i < NC; i++) begin
         if (q_gap && (i % 2 == 1)) begin
            bus.q_valid = 1'b0;
            bus.q_char = CW'($urandom);
            drive_score(0);
            @(negedge clock);
            checks++;
            if (bus.cell_q_we !== '0 || bus.q_ready !== 1'b1) begin
               errors++;
               $display("FAIL load_gap: we=%h ready=%b expected we=0 ready=1", bus.cell_q_we, bus.q_ready);
            end
            step();
         end
         bus.q_valid = 1'b1;
         bus.q_char = qch[i];
         bus.ref_valid = 1'b1;
         drive_score(0);
         we_exp = '0;
         we_exp[i] = 1'b1;
         @(negedge clock);
         checks++;
         if (bus.cell_q_we !== we_exp) begin
            errors++; $display("FAIL cell_q_we[%0d]: got %h expected %h", i, bus.cell_q_we, we_exp);
         end
         checks++;
         if (bus.cell_q_char !== qch[i]) begin
            errors++; $display("FAIL cell_q_char[%0d]: got %0d expected %0d", i, bus.cell_q_char, qch[i]);
         end
         checks++;
         if (bus.ref_ready !== 1'b0 || bus.arr_in_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_ref_leak: ref_ready=%b arr_in_valid=%b expected 0 0", bus.ref_ready, bus.arr_in_valid);
         end
         step();
      end
      bus.q_valid = 1'b0;
      bus.ref_valid = 1'b0;
      bus.start_valid = 1'b0;
   endtask

   task automatic do_stream(input int len, input bit bubbles);
      int i;
      bit tog;
      bit bub;
      logic [CW-1:0] e;
      i = 0;
      tog = 1'b0;
      while (i < len) begin
         bub = bubbles && tog;
         bus.ref_valid = !bub;
         bus.ref_char = CW'($urandom);
         if (!bub) exp_q.push_back(bus.ref_char);
         drive_score(1);
         @(negedge clock);
         checks++;
         if (bus.ref_ready !== 1'b1) begin
            errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, bus.ref_ready);
         end
         checks++;
         if (bus.arr_in_valid !== !bub) begin
            errors++; $display("FAIL arr_in_valid[%0d]: got %b expected %b", i, bus.arr_in_valid, !bub);
         end
         if (!bub) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.arr_in_char !== e) begin
               errors++; $display("FAIL arr_in_char[%0d]: got %0d expected %0d", i, bus.arr_in_char, e);
            end
         end
         step();
         if (!bub) i++;
         if (bubbles) tog = !tog;
      end
   endtask

   task automatic do_drain();
      for (int d = 0; d < NC; d++) begin
         bus.ref_valid = 1'b1;
         bus.ref_char = CW'($urandom);
         drive_score(1);
         @(negedge clock);
         checks++;
         if (bus.ref_ready !== 1'b0 || bus.arr_in_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_in[%0d]: ref_ready=%b arr_in_valid=%b expected 0 0", d, bus.ref_ready, bus.arr_in_valid);
         end
         checks++;
         if (bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL drain_res_early[%0d]: got %b expected 0", d, bus.res_valid);
         end
         step();
      end
      bus.ref_valid = 1'b0;
   endtask

   task automatic do_result(input int hold);
      logic [SW-1:0] eb;
      logic [LW-1:0] ep;
      model(eb, ep);
      drive_score(0);
      bus.res_ready = (hold == 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clock);
         checks++;
         if (bus.res_valid !== 1'b1 || bus.res_score !== eb || bus.res_pos !== ep) begin
            errors++;
            $display("FAIL res_hold[%0d]: valid=%b score=%0d pos=%0d expected 1 %0d %0d",
                     h, bus.res_valid, bus.res_score, bus.res_pos, eb, ep);
         end
         checks++;
         if (bus.start_ready !== 1'b0) begin
            errors++; $display("FAIL start_ready_in_result: got %b expected 0", bus.start_ready);
         end
         step();
      end
      bus.res_ready = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.res_valid !== 1'b1) begin
         errors++; $display("FAIL res_valid: got %b expected 1", bus.res_valid);
      end
      checks++;
      if (bus.res_score !== eb) begin
         errors++; $display("FAIL res_score: got %0d expected %0d", bus.res_score, eb);
      end
      checks++;
      if (bus.res_pos !== ep) begin
         errors++; $display("FAIL res_pos: got %0d expected %0d", bus.res_pos, ep);
      end
      step();
      bus.res_ready = 1'b0;
      bus.arr_score_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_result: res_valid=%b start_ready=%b busy=%b expected 0 1 0",
                  bus.res_valid, bus.start_ready, busy);
      end
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start_valid = 1'b1;
      bus.start_ref_len = 16'd5;
      bus.q_valid = 1'b1;
      bus.q_char = CH_T;
      bus.ref_valid = 1'b1;
      bus.ref_char = CH_G;
      bus.arr_score_valid = 1'b1;
      bus.arr_score = '1;
      bus.res_ready = 1'b1;
      repeat (2) step();
      @(negedge clock);
      checks++;
      if (bus.start_ready !== 1'b0 || state !== ST_IDLE) begin
         errors++; $display("FAIL in_reset: start_ready=%b state=%0d expected 0 0", bus.start_ready, state);
      end
      step();
      reset = 1'b0;
      bus.start_valid = 1'b0;
      bus.start_ref_len = '0;
      bus.q_valid = 1'b0;
      bus.q_char = '0;
      bus.ref_valid = 1'b0;
      bus.ref_char = '0;
      bus.arr_score_valid = 1'b0;
      bus.arr_score = '0;
      bus.res_ready = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.start_ready !== 1'b1) begin
         errors++; $display("FAIL reset_start_ready: got %b expected 1", bus.start_ready);
      end
      checks++;
      if ({bus.q_ready, bus.ref_ready, bus.arr_clear, bus.cell_q_we, bus.cell_q_char,
           bus.arr_in_valid, bus.arr_in_char, bus.res_valid, bus.res_score, bus.res_pos, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: q_ready=%b ref_ready=%b clr=%b we=%h res_valid=%b score=%0d pos=%0d busy=%b expected all 0",
                  bus.q_ready, bus.ref_ready, bus.arr_clear, bus.cell_q_we, bus.res_valid,
                  bus.res_score, bus.res_pos, busy);
      end
      step();
   endtask

   task automatic test_basic();
      for (int i = 0; i < NC; i++) qch[i] = CW'($urandom);
      rand_scores = 1'b0;
      plan_q = {3, 7, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0};
      do_start(4);
      do_load(1'b0);
      do_stream(4, 1'b0);
      do_drain();
      do_result(0);
   endtask

   task automatic test_query_load();
      for (int i = 0; i < NC; i++) qch[i] = CW'(i % 4);
      rand_scores = 1'b1;
      do_start(2);
      do_load(1'b1);
      do_stream(2, 1'b0);
      do_drain();
      do_result(0);
   endtask

   task automatic test_ref_bubbles();
      for (int i = 0; i < NC; i++) qch[i] = CW'($urandom);
      rand_scores = 1'b1;
      do_start(3);
      do_load(1'b0);
      do_stream(3, 1'b1);
      do_drain();
      do_result(0);
   endtask

   task automatic test_ref_len_zero();
      for (int i = 0; i < NC; i++) qch[i] = CW'($urandom);
      rand_scores = 1'b0;
      plan_q.delete();
      do_start(0);
      do_load(1'b0);
      do_drain();
      do_result(0);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < NC; i++) qch[i] = CW'($urandom);
      rand_scores = 1'b1;
      do_start(5);
      do_load(1'b0);
      do_stream(5, 1'b0);
      do_drain();
      do_result(5);
   endtask

   task automatic test_reset_mid_job();
      for (int i = 0; i < NC; i++) qch[i] = CW'($urandom);
      rand_scores = 1'b0;
      plan_q = {500, 600};
      do_start(10);
      do_load(1'b0);
      do_stream(2, 1'b0);
      reset = 1'b1;
      bus.start_valid = 1'b1;
      bus.q_valid = 1'b1;
      bus.ref_valid = 1'b1;
      bus.res_ready = 1'b1;
      @(negedge clock);
      checks++;
      if ({bus.start_ready, bus.q_ready, bus.ref_ready, bus.res_valid, bus.arr_in_valid} !== 5'b0) begin
         errors++;
         $display("FAIL mid_reset_ready: start=%b q=%b ref=%b res_valid=%b in_valid=%b expected all 0",
                  bus.start_ready, bus.q_ready, bus.ref_ready, bus.res_valid, bus.arr_in_valid);
      end
      step();
      reset = 1'b0;
      bus.start_valid = 1'b0;
      bus.q_valid = 1'b0;
      bus.ref_valid = 1'b0;
      bus.res_ready = 1'b0;
      bus.arr_score_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL after_mid_reset: start_ready=%b res_valid=%b busy=%b expected 1 0 0",
                  bus.start_ready, bus.res_valid, busy);
      end
      step();
      plan_q = {5, 9, 2};
      do_start(3);
      do_load(1'b0);
      do_stream(3, 1'b0);
      do_drain();
      do_result(0);
   endtask

   task automatic test_random_jobs();
      int len;
      rand_scores = 1'b1;
      for (int j = 0; j < 4; j++) begin
         len = int'($urandom_range(0, 12));
         for (int i = 0; i < NC; i++) qch[i] = CW'($urandom);
         do_start(len);
         do_load(1'($urandom_range(0, 1)));
         if (len > 0) do_stream(len, 1'($urandom_range(0, 1)));
         do_drain();
         do_result(int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_query_load();
      test_ref_bubbles();
      test_ref_len_zero();
      test_backpressure();
      test_reset_mid_job();
      test_random_jobs();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sw_array_ctrl.md
Name: sw_array_ctrl

Overview:
- Sequencer for the linear systolic array of Smith-Waterman cells.
- Per alignment job it:
  - clears the array;
  - loads one query character into each cell;
  - streams the reference sequence through the array;
  - drains the pipeline;
  - returns the best local-alignment score and the position where it occurred.
- Sits between the host-side job/stream interfaces and the cell array.

Parameters:
- NUM_CELLS, 8, number of cells in the array (query length per job)
- CHAR_W, 2, bits per sequence character (DNA alphabet)
- SCORE_W, 16, unsigned score width from the array
- LEN_W, 16, reference length / position counter width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start_valid  in  1  job request
- start_ready  out  1  controller idle, can accept a job
- start_ref_len  in  LEN_W  reference characters in this job, sampled on start handshake
- q_valid  in  1  query character offered
- q_ready  out  1  controller accepts query character
- q_char  in  CHAR_W  query character
- ref_valid  in  1  reference character offered
- ref_ready  out  1  controller accepts reference character
- ref_char  in  CHAR_W  reference character
- arr_clear  out  1  clears all cell H/E/F state
- cell_q_we  out  NUM_CELLS  one-hot query-register write enable, bit i = cell i
- cell_q_char  out  CHAR_W  query character to write
- arr_in_valid  out  1  reference character enters cell 0 this cycle
- arr_in_char  out  CHAR_W  reference character to cell 0
- arr_score_valid  in  1  last cell presents a score this cycle
- arr_score  in  SCORE_W  score from the array
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_score  out  SCORE_W  best score of the job
- res_pos  out  LEN_W  0-based index of the score sample that produced res_score
- busy  out  1  state != IDLE

Behaviour:
- Clock/reset are fixed: one clock, `clock`; reset is synchronous and active-high, port `reset`.
- Reset:
  - state=IDLE; all counters, best_score and best_pos cleared.
  - Outputs in the cycle after reset: start_ready=1, all other outputs 0.
- Reset asserted mid-job:
  - job abandoned, returns to IDLE;
  - no res_valid issued; no ready asserted while reset is high.
- FSM states: IDLE, CLEAR, LOAD, STREAM, DRAIN, RESULT.
- IDLE:
  - start_ready=1.
  - On start_valid in cycle T: latch start_ref_len, go to CLEAR at T+1.
- CLEAR (exactly 1 cycle):
  - arr_clear=1; best_score=0, best_pos=0, sample_cnt=0, q_idx=0.
  - Next state: LOAD.
- LOAD:
  - q_ready=1.
  - On each q handshake: cell_q_we=(1<<q_idx) in the same cycle; cell_q_char=q_char (combinational pass-through); q_idx++.
  - After handshake q_idx==NUM_CELLS-1: go to STREAM, or to DRAIN if ref_len==0.
  - cell_q_we=0 whenever there is no handshake.
- STREAM:
  - ref_ready=1; arr_in_valid=ref_valid; arr_in_char=ref_char.
  - Count handshakes; after handshake number ref_len, go to DRAIN.
  - Bubbles (ref_valid=0) are legal; arr_in_valid is then 0.
- DRAIN:
  - Exactly NUM_CELLS cycles with arr_in_valid=0, then RESULT.
- Score tracking:
  - Active in STREAM and DRAIN only; arr_score_valid in any other state is ignored.
  - On arr_score_valid: if arr_score > best_score (strict, so the first occurrence wins ties), best_score=arr_score and best_pos=sample_cnt.
  - sample_cnt++ on every valid sample, saturating at 2^LEN_W-1.
- RESULT:
  - res_valid=1; res_score/res_pos held stable until res_ready.
  - On handshake: go to IDLE, res_valid=0 next cycle.
- Handshake inputs are ignored outside their state; no ready is asserted outside its state.
- Job latency (no bubbles) from start handshake to res_valid: 1 + 1 + NUM_CELLS + ref_len + NUM_CELLS cycles.

Decomposition:
- Shared package (sw_pkg):
  - state enum;
  - CHAR_W / SCORE_W / LEN_W defaults;
  - DNA character encoding constants (A=0, C=1, G=2, T=3).
- One natural sub-module, sw_max_tracker:
  - best_score/best_pos/sample_cnt;
  - clear and enable inputs;
  - strict-greater compare.
- FSM and counters stay in sw_array_ctrl.

Test Plan:
- Basic job (NUM_CELLS=8): start, ref_len=4, query 8 chars, 4 ref chars, scores 3,7,5,7 then 0s in DRAIN -> res_score=7, res_pos=1, res_valid exactly 2+8+4+8=22 cycles after start handshake.
- Query load check: q_chars 0..3 repeated -> cell_q_we walks 0x01..0x80 one per handshake; cell_q_char matches each q_char; q_valid gaps produce cell_q_we=0.
- Reference bubbles: ref_valid toggled 1,0,1,0,... for ref_len=3 -> exactly 3 arr_in_valid pulses carrying the offered chars; DRAIN starts only after the third handshake.
- ref_len=0: after LOAD goes straight to DRAIN (8 cycles); no scores -> res_score=0, res_pos=0.
- Result backpressure: res_ready held 0 for 5 cycles -> res_valid and outputs stable; start_ready=0 until res handshake; start_ready=1 the following cycle.
- Reset in STREAM after 2 of 10 ref chars -> next cycle IDLE, start_ready=1, res_valid=0; a new job then reports only its own scores.
